// File: rtl/dimc_tile_seq_if.sv
// Command port of the DIMC tile job sequencer: one job per valid/ready handshake.
interface dimc_tile_seq_if #(
  parameter int FEAT_CNT_W = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [FEAT_CNT_W-1:0] cmd_feat_count;
  logic                  cmd_psout_mode;
  logic                  cmd_compute_mask;
  logic                  cmd_soft_reset;

  modport master (
    output cmd_valid, cmd_feat_count, cmd_psout_mode, cmd_compute_mask, cmd_soft_reset,
    input  cmd_ready
  );
  modport slave (
    input  cmd_valid, cmd_feat_count, cmd_psout_mode, cmd_compute_mask, cmd_soft_reset,
    output cmd_ready
  );
endinterface

// File: rtl/dimc_tile_seq.sv
// Job sequencer for the DIMC tile wrapper: programs static controls, optional soft
// reset, gated feature feed, fixed compute window, output drain, watchdog abort.
module dimc_tile_seq #(
  parameter int FEAT_CNT_W     = 8,
  parameter int SRST_CYCLES    = 4,
  parameter int COMPUTE_CYCLES = 16,
  parameter int TIMEOUT        = 255
) (
  input  logic                  dimc_tilewrap_clk,
  input  logic                  resetn,
  dimc_tile_seq_if.slave        cmd,
  input  logic                  feat_buff_empty,
  input  logic                  psin_buff_empty,
  input  logic                  sout_buff_full,
  input  logic                  sout_buff_empty,
  input  logic                  psout_buff_full,
  input  logic                  psout_buff_empty,
  output logic                  SOFT_RESET,
  output logic                  feat_en,
  output logic                  tile_en,
  output logic [FEAT_CNT_W-1:0] valid_feat_count,
  output logic                  psout_mode,
  output logic                  compute_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int PH_MAX = (SRST_CYCLES > COMPUTE_CYCLES) ? SRST_CYCLES : COMPUTE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SRST, FEED, COMPUTE, DRAIN, DONE, ABORT} state_t;

  state_t                state, state_nxt;
  logic [PH_W-1:0]       ph;
  logic [FEAT_CNT_W-1:0] fed;
  logic [WD_W-1:0]       wd;
  logic                  accept, cmd_ok, stall, beat, drained, wd_exp, timed;

  // Handshake and beat terms come straight from state so the comb block has no loops.
  assign accept  = cmd.cmd_valid & (state == IDLE);
  assign cmd_ok  = cmd.cmd_feat_count != '0;
  assign stall   = sout_buff_full | (psout_mode & psout_buff_full);
  assign beat    = (state == FEED) & !stall & !feat_buff_empty & (!psout_mode | !psin_buff_empty);
  assign drained = sout_buff_empty & (!psout_mode | psout_buff_empty);
  assign wd_exp  = wd == WD_W'(TIMEOUT - 1);
  assign timed   = (state == SRST) | (state == COMPUTE) | (state == ABORT);

  always_comb begin
    state_nxt     = state;
    cmd.cmd_ready = 1'b0;
    SOFT_RESET    = 1'b0;
    feat_en       = 1'b0;
    tile_en       = 1'b0;
    done          = 1'b0;
    busy          = state != IDLE;
    case (state)
      IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (accept && cmd_ok) state_nxt = cmd.cmd_soft_reset ? SRST : FEED;
      end
      SRST: begin
        SOFT_RESET = 1'b1;
        if (ph == PH_W'(SRST_CYCLES - 1)) state_nxt = FEED;
      end
      FEED: begin
        tile_en = 1'b1;
        feat_en = !stall;
        if (beat && fed == valid_feat_count - FEAT_CNT_W'(1)) state_nxt = COMPUTE;
        else if (!beat && wd_exp)                             state_nxt = ABORT;
      end
      COMPUTE: begin
        tile_en = 1'b1;
        if (ph == PH_W'(COMPUTE_CYCLES - 1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        tile_en = 1'b1;
        if (drained)     state_nxt = DONE;
        else if (wd_exp) state_nxt = ABORT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ABORT: begin
        SOFT_RESET = 1'b1;
        if (ph == PH_W'(SRST_CYCLES - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge dimc_tilewrap_clk) begin
    if (!resetn) begin
      state            <= IDLE;
      ph               <= '0;
      fed              <= '0;
      wd               <= '0;
      valid_feat_count <= '0;
      psout_mode       <= 1'b0;
      compute_mask     <= 1'b0;
      err              <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= (accept && !cmd_ok) || (state_nxt == ABORT && state != ABORT);
      if (accept && cmd_ok) begin
        valid_feat_count <= cmd.cmd_feat_count;
        psout_mode       <= cmd.cmd_psout_mode;
        compute_mask     <= cmd.cmd_compute_mask;
      end
      // Phase counter restarts on every state change, so each timed state begins at 0.
      ph <= (timed && state_nxt == state) ? ph + 1'b1 : '0;
      if (accept)    fed <= '0;
      else if (beat) fed <= fed + 1'b1;
      // Watchdog only runs while staying in FEED/DRAIN without a beat; it is 0 on entry.
      if ((state == FEED || state == DRAIN) && state_nxt == state && !beat) wd <= wd + 1'b1;
      else                                                                  wd <= '0;
    end
  end
endmodule

// File: tb/tb_dimc_tile_seq.sv
// Directed bench for dimc_tile_seq: per-scenario tasks with hand-computed cycle timing.
`timescale 1ns/1ps
module tb_dimc_tile_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic feat_buff_empty = 1'b0, psin_buff_empty = 1'b0, sout_buff_full = 1'b0;
  logic sout_buff_empty = 1'b1, psout_buff_full = 1'b0, psout_buff_empty = 1'b1;
  logic SOFT_RESET, feat_en, tile_en, psout_mode, compute_mask, busy, done, err;
  logic [W-1:0] valid_feat_count;
  int n_chk = 0;
  int n_fail = 0;

  dimc_tile_seq_if #(.FEAT_CNT_W(W)) cmd_if ();

  dimc_tile_seq #(.FEAT_CNT_W(W), .SRST_CYCLES(4), .COMPUTE_CYCLES(16), .TIMEOUT(255)) dut (
    .dimc_tilewrap_clk(clk), .resetn(resetn), .cmd(cmd_if),
    .feat_buff_empty(feat_buff_empty), .psin_buff_empty(psin_buff_empty),
    .sout_buff_full(sout_buff_full), .sout_buff_empty(sout_buff_empty),
    .psout_buff_full(psout_buff_full), .psout_buff_empty(psout_buff_empty),
    .SOFT_RESET(SOFT_RESET), .feat_en(feat_en), .tile_en(tile_en),
    .valid_feat_count(valid_feat_count), .psout_mode(psout_mode),
    .compute_mask(compute_mask), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Drives a command during the cycle after the next negedge (the accept cycle T).
  task automatic send_cmd(input logic [W-1:0] cnt, input logic mode, input logic mask, input logic srst);
    @(negedge clk);
    cmd_if.cmd_valid        = 1'b1;
    cmd_if.cmd_feat_count   = cnt;
    cmd_if.cmd_psout_mode   = mode;
    cmd_if.cmd_compute_mask = mask;
    cmd_if.cmd_soft_reset   = srst;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({SOFT_RESET, feat_en, tile_en, busy, done, err, psout_mode, compute_mask} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {SOFT_RESET, feat_en, tile_en, busy, done, err, psout_mode, compute_mask});
    end
    n_chk++;
    if (valid_feat_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", valid_feat_count);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk); #1;
    n_chk++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_if.cmd_ready);
    end
  endtask

  task automatic test_basic();
    int fe_n, fe_first, fe_last, done_n, done_at, rdy_n;
    fe_n = 0; fe_first = -1; fe_last = -1; done_n = 0; done_at = -1; rdy_n = 0;
    send_cmd(8'd3, 1'b0, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_ready_idle: got %b expected 1", cmd_if.cmd_ready);
    end
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.cmd_valid = 1'b0;
      #1;
      if (feat_en) begin fe_n++; if (fe_first < 0) fe_first = k; fe_last = k; end
      if (done) begin done_n++; done_at = k; end
      if (cmd_if.cmd_ready) rdy_n++;
      if (k == 1) begin
        n_chk++;
        if ({valid_feat_count, psout_mode, compute_mask} !== {8'd3, 1'b0, 1'b1}) begin
          n_fail++; $display("FAIL basic_latch: got %0d/%b/%b expected 3/0/1",
                             valid_feat_count, psout_mode, compute_mask);
        end
      end
      if (k == 20) begin
        n_chk++;
        if (tile_en !== 1'b1) begin n_fail++; $display("FAIL basic_drain_tile_en: got %b expected 1", tile_en); end
      end
      if (k == 21) begin
        n_chk++;
        if ({tile_en, busy} !== 2'b01) begin n_fail++; $display("FAIL basic_done_state: got %b expected 01", {tile_en, busy}); end
      end
    end
    n_chk++;
    if (fe_n != 3 || fe_first != 1 || fe_last != 3) begin
      n_fail++; $display("FAIL basic_feat_en: got n=%0d first=%0d last=%0d expected 3/1/3", fe_n, fe_first, fe_last);
    end
    n_chk++;
    if (done_n != 1 || done_at != 21) begin
      n_fail++; $display("FAIL basic_done: got n=%0d at=%0d expected 1/21", done_n, done_at);
    end
    n_chk++;
    if (rdy_n != 3) begin n_fail++; $display("FAIL basic_ready_window: got %0d expected 3", rdy_n); end
    n_chk++;
    if (valid_feat_count !== 8'd3) begin n_fail++; $display("FAIL basic_count_hold: got %0d expected 3", valid_feat_count); end
  endtask

  task automatic test_soft_reset();
    int sr_n, sr_first, fe_n, fe_first, done_n, done_at, err_n;
    sr_n = 0; sr_first = -1; fe_n = 0; fe_first = -1; done_n = 0; done_at = -1; err_n = 0;
    send_cmd(8'd2, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.cmd_valid = 1'b0;
      sout_buff_empty = !(k >= 23 && k <= 25);
      #1;
      if (SOFT_RESET) begin sr_n++; if (sr_first < 0) sr_first = k; end
      if (feat_en) begin fe_n++; if (fe_first < 0) fe_first = k; end
      if (done) begin done_n++; done_at = k; end
      if (err) err_n++;
      if (k == 1) begin
        n_chk++;
        if (compute_mask !== 1'b0) begin n_fail++; $display("FAIL srst_mask: got %b expected 0", compute_mask); end
      end
    end
    sout_buff_empty = 1'b1;
    n_chk++;
    if (sr_n != 4 || sr_first != 1) begin
      n_fail++; $display("FAIL srst_pulse: got n=%0d first=%0d expected 4/1", sr_n, sr_first);
    end
    n_chk++;
    if (fe_n != 2 || fe_first != 5) begin
      n_fail++; $display("FAIL srst_feed: got n=%0d first=%0d expected 2/5", fe_n, fe_first);
    end
    n_chk++;
    if (done_n != 1 || done_at != 27 || err_n != 0) begin
      n_fail++; $display("FAIL srst_done: got n=%0d at=%0d err=%0d expected 1/27/0", done_n, done_at, err_n);
    end
  endtask

  task automatic test_ps_mode();
    int fe_n, fe_stall, beats, fe_last, done_at;
    fe_n = 0; fe_stall = 0; beats = 0; fe_last = -1; done_at = -1;
    send_cmd(8'd4, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.cmd_valid = 1'b0;
      psin_buff_empty = (k % 2) == 1;
      psout_buff_full = (k >= 4 && k <= 6);
      #1;
      if (feat_en) begin fe_n++; fe_last = k; end
      if (feat_en && (k >= 4 && k <= 6)) fe_stall++;
      if (feat_en && !psin_buff_empty) beats++;
      if (done) done_at = k;
      if (k == 1) begin
        n_chk++;
        if (psout_mode !== 1'b1) begin n_fail++; $display("FAIL ps_mode_latch: got %b expected 1", psout_mode); end
      end
    end
    psin_buff_empty = 1'b0; psout_buff_full = 1'b0;
    n_chk++;
    if (fe_stall != 0) begin n_fail++; $display("FAIL ps_stall_feat_en: got %0d expected 0", fe_stall); end
    n_chk++;
    if (fe_n != 9 || beats != 4 || fe_last != 12) begin
      n_fail++; $display("FAIL ps_beats: got fe=%0d beats=%0d last=%0d expected 9/4/12", fe_n, beats, fe_last);
    end
    n_chk++;
    if (done_at != 30) begin n_fail++; $display("FAIL ps_done_at: got %0d expected 30", done_at); end
  endtask

  task automatic test_zero_count();
    int done_at, fe_first;
    done_at = -1; fe_first = -1;
    send_cmd(8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    #1;
    n_chk++;
    if ({err, busy, cmd_if.cmd_ready} !== 3'b101) begin
      n_fail++; $display("FAIL zero_err: got err/busy/ready=%b expected 101", {err, busy, cmd_if.cmd_ready});
    end
    n_chk++;
    if ({valid_feat_count, psout_mode} !== {8'd4, 1'b1}) begin
      n_fail++; $display("FAIL zero_regs_held: got %0d/%b expected 4/1", valid_feat_count, psout_mode);
    end
    @(negedge clk); #1;
    n_chk++;
    if ({err, busy} !== 2'b00) begin n_fail++; $display("FAIL zero_err_pulse: got %b expected 00", {err, busy}); end
    send_cmd(8'd1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.cmd_valid = 1'b0;
      #1;
      if (feat_en && fe_first < 0) fe_first = k;
      if (done) done_at = k;
    end
    n_chk++;
    if (fe_first != 1 || done_at != 19 || valid_feat_count !== 8'd1) begin
      n_fail++; $display("FAIL zero_next_job: got fe=%0d done=%0d cnt=%0d expected 1/19/1", fe_first, done_at, valid_feat_count);
    end
  endtask

  task automatic test_watchdog();
    int fe_n, err_n, err_at, sr_n, sr_first, done_n;
    fe_n = 0; err_n = 0; err_at = -1; sr_n = 0; sr_first = -1; done_n = 0;
    feat_buff_empty = 1'b1;
    send_cmd(8'd2, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 262; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.cmd_valid = 1'b0;
      #1;
      if (feat_en) fe_n++;
      if (err) begin err_n++; err_at = k; end
      if (SOFT_RESET) begin sr_n++; if (sr_first < 0) sr_first = k; end
      if (done) done_n++;
      if (k == 256) begin
        n_chk++;
        if ({tile_en, feat_en} !== 2'b00) begin n_fail++; $display("FAIL wd_abort_gates: got %b expected 00", {tile_en, feat_en}); end
      end
      if (k == 260) begin
        n_chk++;
        if ({cmd_if.cmd_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL wd_idle: got %b expected 10", {cmd_if.cmd_ready, busy}); end
      end
    end
    feat_buff_empty = 1'b0;
    n_chk++;
    if (fe_n != 255) begin n_fail++; $display("FAIL wd_feed_cycles: got %0d expected 255", fe_n); end
    n_chk++;
    if (err_n != 1 || err_at != 256) begin n_fail++; $display("FAIL wd_err: got n=%0d at=%0d expected 1/256", err_n, err_at); end
    n_chk++;
    if (sr_n != 4 || sr_first != 256 || done_n != 0) begin
      n_fail++; $display("FAIL wd_srst: got n=%0d first=%0d done=%0d expected 4/256/0", sr_n, sr_first, done_n);
    end
  endtask

  task automatic test_reset_mid();
    int pulse_n, done_at;
    pulse_n = 0; done_at = -1;
    send_cmd(8'd1, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.cmd_valid = 1'b0;
      if (k == 5) resetn = 1'b0;
      if (k == 6) resetn = 1'b1;
      #1;
      if (k >= 6 && (done || err || SOFT_RESET)) pulse_n++;
      if (k == 6) begin
        n_chk++;
        if ({SOFT_RESET, feat_en, tile_en, busy, done, err, psout_mode, compute_mask, valid_feat_count} !== 16'h0000) begin
          n_fail++; $display("FAIL midreset_outputs: got %b expected all zero",
                             {SOFT_RESET, feat_en, tile_en, busy, done, err, psout_mode, compute_mask, valid_feat_count});
        end
      end
    end
    n_chk++;
    if (pulse_n != 0) begin n_fail++; $display("FAIL midreset_pulses: got %0d expected 0", pulse_n); end
    send_cmd(8'd2, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.cmd_valid = 1'b0;
      #1;
      if (done) done_at = k;
    end
    n_chk++;
    if (done_at != 20 || valid_feat_count !== 8'd2) begin
      n_fail++; $display("FAIL midreset_next_job: got done=%0d cnt=%0d expected 20/2", done_at, valid_feat_count);
    end
  endtask

  initial begin
    cmd_if.cmd_valid        = 1'b0;
    cmd_if.cmd_feat_count   = '0;
    cmd_if.cmd_psout_mode   = 1'b0;
    cmd_if.cmd_compute_mask = 1'b0;
    cmd_if.cmd_soft_reset   = 1'b0;
    test_reset();
    test_basic();
    test_soft_reset();
    test_ps_mode();
    test_zero_count();
    test_watchdog();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
